// File: rtl/pixel_line_fetcher.sv
// pixel_line_fetcher: double-buffered line prefetcher for the pixel-plane renderer.
// While line N is displayed from the front buffer, framebuffer line N+1 is read from
// VRAMpixel (through an arbiter grant) into the back buffer.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   line_start            hblank pulse: swap buffers, start fetch of line_idx
//   line_idx, halfRes     line to fetch and half-res mode, sampled at line_start
//   vram_addr, vram_rd    VRAM read request (address is 0 while vram_rd is low)
//   vram_gnt, vram_q      arbiter grant and read data (RD_LATENCY cycles after accept)
//   rd_x, rd_q            renderer column in, front-buffer pixel out one cycle later
//   busy, line_done       fetch in progress, 1-cycle pulse on the last word written
//   underrun              sticky: line_start arrived while a fetch was in progress
//   fetch_cycles          fetch duration statistic (PIXEL_FETCH_STATS_EN), else 0
//
// Optional feature macro: PIXEL_FETCH_STATS_EN
module pixel_line_fetcher #(
  parameter int unsigned LINE_PIXELS = 320,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [8:0]        line_idx,
  input  logic              halfRes,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic              vram_gnt,
  input  logic [23:0]       vram_q,
  input  logic [8:0]        rd_x,
  output logic [23:0]       rd_q,
  output logic              busy,
  output logic              line_done,
  output logic              underrun,
  output logic [10:0]       fetch_cycles
);

  localparam int unsigned IDX_W = $clog2(LINE_PIXELS);
  localparam int unsigned CNT_W = $clog2(LINE_PIXELS + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  front_sel_q, front_sel_d;
  logic [1:0]            half_buf_q, half_buf_d;   // halfRes latched per buffer
  logic [CNT_W-1:0]      n_q, n_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [CNT_W-1:0]      issue_q, issue_d;
  logic [CNT_W-1:0]      wr_q, wr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                  vram_rd_q, vram_rd_d;
  logic [ADDR_W-1:0]     vram_addr_q, vram_addr_d;
  logic                  busy_q, busy_d;
  logic                  line_done_q, line_done_d;
  logic                  underrun_q, underrun_d;
  logic [23:0]           rd_q_q, rd_q_d;

  logic                  accept_c;
  logic                  start_c;
  logic                  abort_c;
  logic                  wr_en_c;
  logic [CNT_W-1:0]      issue_inc_c;
  logic [CNT_W-1:0]      wr_inc_c;
  logic [8:0]            line_sel_c;
  logic [ADDR_W-1:0]     base_new_c;
  logic [CNT_W-1:0]      n_new_c;
  logic [8:0]            rd_sel_c;

  // Two line buffers; index front_sel is the read side, the other is written.
  logic [23:0] line_mem [2][LINE_PIXELS];

  // Next-state, counters and read port.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    half_buf_d  = half_buf_q;
    n_d         = n_q;
    base_d      = base_q;
    issue_d     = issue_q;
    wr_d        = wr_q;
    vram_rd_d   = vram_rd_q;
    vram_addr_d = vram_addr_q;
    underrun_d  = underrun_q;
    line_done_d = 1'b0;
    wr_en_c     = 1'b0;
    start_c     = 1'b0;
    abort_c     = 1'b0;
    rd_q_d      = '0;

    accept_c    = vram_rd_q && vram_gnt;
    // Valid pipeline: bit 0 takes the new acceptance, the top bit marks returning data.
    vld_d       = RD_LATENCY'({vld_q, accept_c});
    issue_inc_c = issue_q + CNT_W'(1);
    wr_inc_c    = wr_q + CNT_W'(1);

    line_sel_c  = halfRes ? {1'b0, line_idx[8:1]} : line_idx;
    base_new_c  = ADDR_W'(line_sel_c) * ADDR_W'(LINE_PIXELS);
    n_new_c     = halfRes ? CNT_W'(LINE_PIXELS / 2) : CNT_W'(LINE_PIXELS);

    case (state_q)
      ST_IDLE: begin
        if (line_start) start_c = 1'b1;
      end
      ST_FETCH: begin
        if (line_start) begin
          start_c = 1'b1;
          abort_c = 1'b1;
        end else begin
          if (accept_c) begin
            issue_d     = issue_inc_c;
            vram_rd_d   = (issue_inc_c < n_q);
            vram_addr_d = vram_rd_d ? (base_q + ADDR_W'(issue_inc_c)) : '0;
          end
          if (vld_q[RD_LATENCY-1]) begin
            wr_en_c = 1'b1;
            wr_d    = wr_inc_c;
            if (wr_inc_c == n_q) begin
              line_done_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every line_start swaps and (re)starts; in-flight returns are dropped.
    if (start_c) begin
      front_sel_d             = ~front_sel_q;
      half_buf_d[front_sel_q] = halfRes;   // old front becomes the new back
      n_d                     = n_new_c;
      base_d                  = base_new_c;
      issue_d                 = '0;
      wr_d                    = '0;
      vld_d                   = '0;
      vram_rd_d               = 1'b1;
      vram_addr_d             = base_new_c;
      state_d                 = ST_FETCH;
    end
    if (abort_c) underrun_d = 1'b1;

    busy_d = (state_d == ST_FETCH);

    rd_sel_c = half_buf_q[front_sel_q] ? {1'b0, rd_x[8:1]} : rd_x;
    if (32'(rd_x) < LINE_PIXELS) rd_q_d = line_mem[front_sel_q][IDX_W'(rd_sel_c)];

    if (reset) wr_en_c = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      half_buf_q  <= '0;
      n_q         <= '0;
      base_q      <= '0;
      issue_q     <= '0;
      wr_q        <= '0;
      vld_q       <= '0;
      vram_rd_q   <= 1'b0;
      vram_addr_q <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      rd_q_q      <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      half_buf_q  <= half_buf_d;
      n_q         <= n_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      wr_q        <= wr_d;
      vld_q       <= vld_d;
      vram_rd_q   <= vram_rd_d;
      vram_addr_q <= vram_addr_d;
      busy_q      <= busy_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
      rd_q_q      <= rd_q_d;
    end
  end

  // Back-buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en_c) line_mem[~front_sel_q][IDX_W'(wr_q)] <= vram_q;
  end

`ifdef PIXEL_FETCH_STATS_EN
  localparam int unsigned STAT_W = 11;

  logic [STAT_W-1:0] cyc_q, cyc_d;
  logic [STAT_W-1:0] fc_q, fc_d;
  logic [STAT_W-1:0] cyc_inc_c;

  // Saturating cycle count from FETCH entry; captured on line_done, forced to max on underrun.
  always_comb begin
    cyc_inc_c = (cyc_q == '1) ? cyc_q : (cyc_q + STAT_W'(1));
    cyc_d     = cyc_q;
    fc_d      = fc_q;
    if (state_q == ST_FETCH) cyc_d = cyc_inc_c;
    if (line_done_d)         fc_d  = cyc_inc_c;
    if (start_c)             cyc_d = '0;
    if (abort_c)             fc_d  = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      fc_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      fc_q  <= fc_d;
    end
  end

  assign fetch_cycles = fc_q;
`else
  assign fetch_cycles = '0;
`endif

  assign vram_addr = vram_addr_q;
  assign vram_rd   = vram_rd_q;
  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign underrun  = underrun_q;
  assign rd_q      = rd_q_q;

endmodule

// File: tb/tb_pixel_line_fetcher.sv
// Directed bench for pixel_line_fetcher: one instance with RD_LATENCY=1 for the
// main scenarios and one with RD_LATENCY=3 for the grant-stall scenario.
module tb_pixel_line_fetcher;

`ifdef PIXEL_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        ls1, half1, gnt1, rd1, busy1, done1, unr1;
  logic [8:0]  idx1, rx1;
  logic [23:0] q1, rq1;
  logic [16:0] addr1;
  logic [10:0] fc1;

  logic        ls3, half3, gnt3, rd3, busy3, done3, unr3;
  logic [8:0]  idx3, rx3;
  logic [23:0] q3, rq3;
  logic [16:0] addr3;
  logic [10:0] fc3;
  logic [16:0] p3_0, p3_1;

  int checks = 0;
  int errors = 0;

  pixel_line_fetcher #(.LINE_PIXELS(320), .ADDR_W(17), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .line_start(ls1), .line_idx(idx1), .halfRes(half1),
    .vram_addr(addr1), .vram_rd(rd1), .vram_gnt(gnt1), .vram_q(q1), .rd_x(rx1),
    .rd_q(rq1), .busy(busy1), .line_done(done1), .underrun(unr1), .fetch_cycles(fc1)
  );

  pixel_line_fetcher #(.LINE_PIXELS(320), .ADDR_W(17), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .line_start(ls3), .line_idx(idx3), .halfRes(half3),
    .vram_addr(addr3), .vram_rd(rd3), .vram_gnt(gnt3), .vram_q(q3), .rd_x(rx3),
    .rd_q(rq3), .busy(busy3), .line_done(done3), .underrun(unr3), .fetch_cycles(fc3)
  );

  // VRAM models: data word = address, returned RD_LATENCY cycles after the request edge.
  always @(posedge clk) q1 <= {7'b0, addr1};
  always @(posedge clk) begin
    p3_0 <= addr3;
    p3_1 <= p3_0;
    q3   <= {7'b0, p3_1};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1(input logic [8:0] idx, input logic h);
    idx1 = idx; half1 = h; ls1 = 1'b1;
    tick();
    ls1 = 1'b0;
  endtask

  task automatic pulse3(input logic [8:0] idx, input logic h);
    idx3 = idx; half3 = h; ls3 = 1'b1;
    tick();
    ls3 = 1'b0;
  endtask

  task automatic wait_idle1(input string name);
    for (int c = 0; c < 1000 && busy1; c++) tick();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b, want 0 within 1000 cycles", name, busy1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ls1 = 0; idx1 = 0; half1 = 0; gnt1 = 0; rx1 = 0;
    ls3 = 0; idx3 = 0; half3 = 0; gnt3 = 0; rx3 = 0;
    tick(); tick(); tick();
    checks++;
    if ({rd1, busy1, done1, unr1} !== 4'b0 || addr1 !== 17'd0 || rq1 !== 24'd0 || fc1 !== 11'd0) begin
      errors++;
      $display("FAIL reset_dut1: rd=%0b busy=%0b done=%0b unr=%0b addr=%0d rq=%0d fc=%0d, want all 0",
               rd1, busy1, done1, unr1, addr1, rq1, fc1);
    end
    checks++;
    if ({rd3, busy3, done3, unr3} !== 4'b0 || addr3 !== 17'd0 || rq3 !== 24'd0 || fc3 !== 11'd0) begin
      errors++;
      $display("FAIL reset_dut3: rd=%0b busy=%0b done=%0b unr=%0b addr=%0d rq=%0d fc=%0d, want all 0",
               rd3, busy3, done3, unr3, addr3, rq3, fc3);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_res();
    gnt1 = 1'b1;
    pulse1(9'd5, 1'b0);
    for (int i = 0; i < 320; i++) begin
      checks++;
      if (rd1 !== 1'b1 || addr1 !== 17'(1600 + i)) begin
        errors++;
        $display("FAIL full_addr[%0d]: rd=%0b addr=%0d, want rd=1 addr=%0d", i, rd1, addr1, 1600 + i);
      end
      tick();
    end
    checks++;
    if (rd1 !== 1'b0 || addr1 !== 17'd0 || done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: rd=%0b addr=%0d done=%0b busy=%0b, want 0 0 0 1", rd1, addr1, done1, busy1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || fc1 !== (STATS ? 11'd321 : 11'd0)) begin
      errors++;
      $display("FAIL full_done: done=%0b busy=%0b fc=%0d, want 1 0 %0d", done1, busy1, fc1, STATS ? 321 : 0);
    end
    tick();
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse: done=%0b, want 0", done1);
    end
  endtask

  // Half-res fetch of line 9, reading back the full-res line 5 meanwhile.
  task automatic test_half_res();
    int rxv [6];
    int rexp [6];
    rxv  = '{7, 0, 319, 320, 511, 100};
    rexp = '{1607, 1600, 1919, 0, 0, 1700};
    pulse1(9'd9, 1'b1);
    for (int i = 0; i < 160; i++) begin
      if (i >= 1 && i <= 6) begin
        checks++;
        if (rq1 !== 24'(rexp[i-1])) begin
          errors++;
          $display("FAIL front_read[x=%0d]: rd_q=%0d, want %0d", rxv[i-1], rq1, rexp[i-1]);
        end
      end
      if (i < 6) rx1 = 9'(rxv[i]);
      checks++;
      if (rd1 !== 1'b1 || addr1 !== 17'(1280 + i)) begin
        errors++;
        $display("FAIL half_addr[%0d]: rd=%0b addr=%0d, want rd=1 addr=%0d", i, rd1, addr1, 1280 + i);
      end
      tick();
    end
    checks++;
    if (rd1 !== 1'b0) begin
      errors++;
      $display("FAIL half_count: rd=%0b after 160 reads, want 0", rd1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("FAIL half_done: done=%0b, want 1", done1);
    end
  endtask

  // After the swap the half-res buffer is in front: each word covers two columns.
  task automatic test_half_read();
    int rxv [5];
    int rexp [5];
    rxv  = '{10, 11, 0, 319, 320};
    rexp = '{1285, 1285, 1280, 1439, 0};
    pulse1(9'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rx1 = 9'(rxv[i]);
      tick();
      checks++;
      if (rq1 !== 24'(rexp[i])) begin
        errors++;
        $display("FAIL half_read[x=%0d]: rd_q=%0d, want %0d", rxv[i], rq1, rexp[i]);
      end
    end
    wait_idle1("half_read");
  endtask

  task automatic test_underrun();
    int rxv [4];
    int rexp [4];
    rxv  = '{0, 1, 2, 319};
    rexp = '{9600, 9601, 9602, 9919};
    pulse1(9'd20, 1'b0);
    for (int i = 0; i < 100; i++) tick();
    pulse1(9'd30, 1'b0);
    checks++;
    if (unr1 !== 1'b1 || busy1 !== 1'b1 || fc1 !== (STATS ? 11'd2047 : 11'd0)) begin
      errors++;
      $display("FAIL underrun_flag: unr=%0b busy=%0b fc=%0d, want 1 1 %0d", unr1, busy1, fc1, STATS ? 2047 : 0);
    end
    for (int i = 0; i < 320; i++) begin
      checks++;
      if (rd1 !== 1'b1 || addr1 !== 17'(9600 + i) || unr1 !== 1'b1) begin
        errors++;
        $display("FAIL underrun_addr[%0d]: rd=%0b addr=%0d unr=%0b, want 1 %0d 1", i, rd1, addr1, unr1, 9600 + i);
      end
      tick();
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || unr1 !== 1'b1) begin
      errors++;
      $display("FAIL underrun_done: done=%0b unr=%0b, want 1 1", done1, unr1);
    end
    pulse1(9'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rx1 = 9'(rxv[i]);
      tick();
      checks++;
      if (rq1 !== 24'(rexp[i]) || unr1 !== 1'b1) begin
        errors++;
        $display("FAIL underrun_data[x=%0d]: rd_q=%0d unr=%0b, want %0d 1", rxv[i], rq1, unr1, rexp[i]);
      end
    end
    wait_idle1("underrun");
  endtask

  // gnt pattern 1,0,0 with RD_LATENCY=3: every address once, held while stalled.
  task automatic test_grant_stall();
    int nexp;
    int ndone;
    nexp  = 0;
    ndone = 0;
    pulse3(9'd5, 1'b0);
    for (int c = 0; c < 1100; c++) begin
      gnt3 = (c % 3 == 0);
      if (rd3) begin
        checks++;
        if (addr3 !== 17'(1600 + nexp)) begin
          errors++;
          $display("FAIL stall_addr[c=%0d]: addr=%0d, want %0d", c, addr3, 1600 + nexp);
        end
        if (gnt3) nexp++;
      end
      tick();
      if (done3) ndone++;
    end
    checks++;
    if (nexp != 320 || ndone != 1 || busy3 !== 1'b0 || unr3 !== 1'b0) begin
      errors++;
      $display("FAIL stall_summary: reads=%0d dones=%0d busy=%0b unr=%0b, want 320 1 0 0",
               nexp, ndone, busy3, unr3);
    end
    gnt3 = 1'b1;
    pulse3(9'd6, 1'b0);
    for (int x = 0; x < 320; x++) begin
      rx3 = 9'(x);
      tick();
      checks++;
      if (rq3 !== 24'(1600 + x)) begin
        errors++;
        $display("FAIL stall_data[x=%0d]: rd_q=%0d, want %0d", x, rq3, 1600 + x);
      end
    end
    for (int c = 0; c < 1000 && busy3; c++) tick();
    checks++;
    if (busy3 !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: busy=%0b, want 0 within 1000 cycles", busy3);
    end
  endtask

  task automatic test_reset_mid();
    pulse1(9'd40, 1'b0);
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (addr1 !== 17'd12850) begin
      errors++;
      $display("FAIL mid_pre: addr=%0d, want 12850", addr1);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({rd1, busy1, unr1, done1} !== 4'b0 || addr1 !== 17'd0 || rq1 !== 24'd0 || fc1 !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset: rd=%0b busy=%0b unr=%0b done=%0b addr=%0d rq=%0d fc=%0d, want all 0",
               rd1, busy1, unr1, done1, addr1, rq1, fc1);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet[%0d]: done=%0b busy=%0b, want 0 0", i, done1, busy1);
      end
    end
    pulse1(9'd41, 1'b0);
    for (int i = 0; i < 320; i++) begin
      checks++;
      if (rd1 !== 1'b1 || addr1 !== 17'(13120 + i)) begin
        errors++;
        $display("FAIL mid_addr[%0d]: rd=%0b addr=%0d, want 1 %0d", i, rd1, addr1, 13120 + i);
      end
      tick();
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || unr1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_done: done=%0b unr=%0b, want 1 0", done1, unr1);
    end
    pulse1(9'd1, 1'b0);
    rx1 = 9'd0;
    tick();
    checks++;
    if (rq1 !== 24'd13120) begin
      errors++;
      $display("FAIL mid_data[x=0]: rd_q=%0d, want 13120", rq1);
    end
    rx1 = 9'd319;
    tick();
    checks++;
    if (rq1 !== 24'd13439) begin
      errors++;
      $display("FAIL mid_data[x=319]: rd_q=%0d, want 13439", rq1);
    end
    wait_idle1("reset_mid");
  endtask

  initial begin
    test_reset();
    test_full_res();
    test_half_res();
    test_half_read();
    test_underrun();
    test_grant_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
